// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage divider front end: op encodings, FSM state, divider latency.
package div_pkg;

   localparam logic [1:0] DIV_W  = 2'b00;
   localparam logic [1:0] MOD_W  = 2'b01;
   localparam logic [1:0] DIV_WU = 2'b10;
   localparam logic [1:0] MOD_WU = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } div_state_t;

   localparam int DIV_LATENCY = 34;

   // op[0] picks remainder over quotient, op[1] picks unsigned.
   function automatic logic op_is_mod(input logic [1:0] op);
      return (op == MOD_W) || (op == MOD_WU);
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == DIV_W) || (op == MOD_W);
   endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// Issue/retire controller for the iterative divider: holds operands for a whole operation and returns the result to MEM.
// Optional DIV_ZERO_BYPASS_EN: a zero divisor skips the divider and produces the architectural result directly.
module div_issue_ctrl (
   input  logic        div_clk,
   input  logic        resetn,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [31:0] in_src1,
   input  logic [31:0] in_src2,
   input  logic [4:0]  in_dest,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [4:0]  out_dest,
   output logic        busy,
   output logic        div_en,
   output logic        div_signed,
   output logic [31:0] div_x,
   output logic [31:0] div_y,
   input  logic [31:0] div_s,
   input  logic [31:0] div_r,
   input  logic        div_complete
);
   import div_pkg::*;

   div_state_t  state_reg;
   logic [1:0]  op_reg;
   logic [31:0] x_reg;
   logic [31:0] y_reg;
   logic [4:0]  dest_reg;
   logic [31:0] result_reg;
   logic        out_valid_reg;
   logic        busy_reg;
   logic        div_en_reg;
   logic        div_signed_reg;

   always_ff @(posedge div_clk or negedge resetn) begin
      if (!resetn) begin
         state_reg      <= IDLE;
         op_reg         <= DIV_W;
         x_reg          <= '0;
         y_reg          <= '0;
         dest_reg       <= '0;
         result_reg     <= '0;
         out_valid_reg  <= 1'b0;
         busy_reg       <= 1'b0;
         div_en_reg     <= 1'b0;
         div_signed_reg <= 1'b0;
      end else if (flush) begin
         // Dropping div_en also rearms the divider's iteration counter.
         state_reg     <= IDLE;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
         div_en_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  op_reg         <= in_op;
                  x_reg          <= in_src1;
                  y_reg          <= in_src2;
                  dest_reg       <= in_dest;
                  div_signed_reg <= op_is_signed(in_op);
                  busy_reg       <= 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
                  if (in_src2 == 32'd0) begin
                     result_reg    <= op_is_mod(in_op) ? in_src1 : 32'hFFFF_FFFF;
                     out_valid_reg <= 1'b1;
                     div_en_reg    <= 1'b0;
                     state_reg     <= DONE;
                  end else begin
                     div_en_reg <= 1'b1;
                     state_reg  <= RUN;
                  end
`else
                  div_en_reg <= 1'b1;
                  state_reg  <= RUN;
`endif
               end
            end
            RUN: begin
               if (div_complete) begin
                  result_reg    <= op_is_mod(op_reg) ? div_r : div_s;
                  out_valid_reg <= 1'b1;
                  div_en_reg    <= 1'b0;
                  state_reg     <= DONE;
               end
            end
            DONE: begin
               // Result and dest are frozen here until MEM takes them.
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg     <= IDLE;
               out_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
               div_en_reg    <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = (state_reg == IDLE);
   assign out_valid  = out_valid_reg;
   assign out_result = result_reg;
   assign out_dest   = dest_reg;
   assign busy       = busy_reg;
   assign div_en     = div_en_reg;
   assign div_signed = div_signed_reg;
   assign div_x      = x_reg;
   assign div_y      = y_reg;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural stand-in for the iterative divider.
// Define DIV_ZERO_BYPASS_EN for both bench and RTL to exercise the zero-divisor bypass.
module tb_div_issue_ctrl;
   import div_pkg::*;

   logic        div_clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_src1;
   logic [31:0] in_src2;
   logic [4:0]  in_dest;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_dest;
   logic        busy;
   logic        div_en;
   logic        div_signed;
   logic [31:0] div_x;
   logic [31:0] div_y;
   logic [31:0] div_s;
   logic [31:0] div_r;
   logic        div_complete;

   int vectors = 0;
   int miscompares = 0;

   always #5 div_clk = ~div_clk;

   div_issue_ctrl dut (
      .div_clk(div_clk), .resetn(resetn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_dest(out_dest), .busy(busy),
      .div_en(div_en), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
      .div_s(div_s), .div_r(div_r), .div_complete(div_complete)
   );

   // Divider stand-in: completes L cycles after div_en first goes high, restarts whenever div_en is low.
   int div_cnt;
   always_ff @(posedge div_clk or negedge resetn) begin
      if (!resetn)      div_cnt <= 0;
      else if (!div_en) div_cnt <= 0;
      else              div_cnt <= div_cnt + 1;
   end
   assign div_complete = div_en && (div_cnt == DIV_LATENCY);

   function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic sgn);
      logic [31:0] ax, ay, q, r;
      if (y == 32'd0) return {32'hFFFF_FFFF, x};
      ax = (sgn && x[31]) ? -x : x;
      ay = (sgn && y[31]) ? -y : y;
      q  = ax / ay;
      r  = ax % ay;
      if (sgn && (x[31] ^ y[31])) q = -q;
      if (sgn && x[31]) r = -r;
      return {q, r};
   endfunction

   assign {div_s, div_r} = ref_div(div_x, div_y, div_signed);

   logic en_seen;
   always @(posedge div_clk) if (div_en) en_seen <= 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drive one request for a single cycle; returns one negedge after the accepting edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
      in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_dest = d;
      @(negedge div_clk);
      in_valid = 1'b0;
   endtask

   // Counts negedges from the first one after accept until out_valid is seen.
   task automatic wait_result(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge div_clk);
         lat++;
      end
      $display("result: lat=%0d out_valid=%0b result=0x%08h dest=%0d", lat, out_valid, out_result, out_dest);
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic [31:0] exp);
      int lat;
      issue(op, a, b, d);
      wait_result(lat);
      chk({tag, "_lat"}, lat, DIV_LATENCY + 2);
      chk({tag, "_res"}, out_result, exp);
      chk({tag, "_dest"}, {27'd0, out_dest}, {27'd0, d});
      @(negedge div_clk);
      chk({tag, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int lat;
      int seen_valid;
      resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
      in_src1 = '0; in_src2 = '0; in_dest = '0; out_ready = 1'b1; en_seen = 1'b0;
      repeat (2) @(negedge div_clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_div_en", {31'd0, div_en}, 32'd0);
      chk("rst_div_signed", {31'd0, div_signed}, 32'd0);
      chk("rst_div_x", div_x, 32'd0);
      chk("rst_div_y", div_y, 32'd0);
      chk("rst_result", out_result, 32'd0);
      chk("rst_dest", {27'd0, out_dest}, 32'd0);
      resetn = 1'b1;
      @(negedge div_clk);

      // Operand drive check on the first cycle of RUN.
      issue(DIV_W, 32'hFFFF_FFF9, 32'h2, 5'd3);
      chk("run_div_en", {31'd0, div_en}, 32'd1);
      chk("run_signed", {31'd0, div_signed}, 32'd1);
      chk("run_x", div_x, 32'hFFFF_FFF9);
      chk("run_y", div_y, 32'h2);
      chk("run_busy", {31'd0, busy}, 32'd1);
      wait_result(lat);
      chk("divw_lat", lat, DIV_LATENCY + 2);
      chk("divw_res", out_result, 32'hFFFF_FFFD);
      chk("divw_dest", {27'd0, out_dest}, 32'd3);
      @(negedge div_clk);
      chk("divw_vld_drop", {31'd0, out_valid}, 32'd0);
      chk("divw_rdy_back", {31'd0, in_ready}, 32'd1);

      run_op("modw", MOD_W, 32'hFFFF_FFF9, 32'h2, 5'd4, 32'hFFFF_FFFF);
      run_op("divwu", DIV_WU, 32'hFFFF_FFF9, 32'h2, 5'd5, 32'h7FFF_FFFC);
      run_op("modwu", MOD_WU, 32'hFFFF_FFF9, 32'h2, 5'd6, 32'h0000_0001);
      run_op("divw_ovf", DIV_W, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000);
      run_op("modw_neg", MOD_W, 32'h0000_0007, 32'hFFFF_FFFE, 5'd8, 32'h0000_0001);

      // Backpressure: hold in DONE for 10 cycles.
      out_ready = 1'b0;
      issue(DIV_W, 32'd100, 32'd7, 5'd9);
      wait_result(lat);
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_res", out_result, 32'd14);
         chk("bp_dest", {27'd0, out_dest}, 32'd9);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_div_en", {31'd0, div_en}, 32'd0);
         @(negedge div_clk);
      end
      out_ready = 1'b1;
      @(negedge div_clk);
      chk("bp_release_vld", {31'd0, out_valid}, 32'd0);
      chk("bp_release_idle", {31'd0, in_ready}, 32'd1);
      chk("bp_release_busy", {31'd0, busy}, 32'd0);

      // Flush 5 cycles into RUN.
      issue(DIV_W, 32'hFFFF_FFF9, 32'h2, 5'd10);
      repeat (4) @(negedge div_clk);
      flush = 1'b1;
      @(negedge div_clk);
      flush = 1'b0;
      chk("fl_div_en", {31'd0, div_en}, 32'd0);
      chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
      seen_valid = 0;
      for (int i = 0; i < 60; i++) begin
         if (out_valid) seen_valid++;
         @(negedge div_clk);
      end
      chk("fl_no_valid", seen_valid, 0);
      run_op("fl_after", DIV_W, 32'd100, 32'd7, 5'd11, 32'd14);

      // Flush coincident with div_complete.
      issue(DIV_WU, 32'd50, 32'd5, 5'd12);
      lat = 0;
      while (!div_complete && lat < 200) begin
         @(negedge div_clk);
         lat++;
      end
      chk("flc_complete_seen", {31'd0, div_complete}, 32'd1);
      flush = 1'b1;
      @(negedge div_clk);
      flush = 1'b0;
      seen_valid = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) seen_valid++;
         @(negedge div_clk);
      end
      chk("flc_no_valid", seen_valid, 0);
      chk("flc_idle", {31'd0, in_ready}, 32'd1);

      // Flush coincident with in_valid in IDLE.
      flush = 1'b1;
      issue(DIV_W, 32'd9, 32'd3, 5'd13);
      flush = 1'b0;
      chk("fli_not_acc", {31'd0, in_ready}, 32'd1);
      chk("fli_busy", {31'd0, busy}, 32'd0);
      chk("fli_div_en", {31'd0, div_en}, 32'd0);

      // Asynchronous reset mid-RUN.
      issue(DIV_W, 32'd9, 32'd3, 5'd14);
      repeat (3) @(negedge div_clk);
      #2 resetn = 1'b0;
      #1;
      chk("arst_div_en", {31'd0, div_en}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_div_x", div_x, 32'd0);
      chk("arst_dest", {27'd0, out_dest}, 32'd0);
      @(negedge div_clk);
      resetn = 1'b1;
      @(negedge div_clk);
      run_op("post_rst", DIV_W, 32'd9, 32'd3, 5'd15, 32'd3);

`ifdef DIV_ZERO_BYPASS_EN
      en_seen = 1'b0;
      issue(DIV_W, 32'd5, 32'd0, 5'd16);
      chk("byp_div_valid", {31'd0, out_valid}, 32'd1);
      chk("byp_div_res", out_result, 32'hFFFF_FFFF);
      chk("byp_div_dest", {27'd0, out_dest}, 32'd16);
      @(negedge div_clk);
      chk("byp_div_drop", {31'd0, out_valid}, 32'd0);
      issue(MOD_WU, 32'd5, 32'd0, 5'd17);
      chk("byp_mod_valid", {31'd0, out_valid}, 32'd1);
      chk("byp_mod_res", out_result, 32'd5);
      @(negedge div_clk);
      chk("byp_no_en", {31'd0, en_seen}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
